// File: rtl/bridge_demux_if.sv
// CPU-to-device bridge bus: CPU request/response handshake plus the device-side fan-out.
// No storage; signals only.
// The master side is the CPU and device models; the bridge takes the slave side.
interface bridge_demux_if;
  // CPU request channel
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  // CPU response channel
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  // device side
  logic [2:0]  dev_sel;
  logic        dev_we;
  logic [31:0] dev_addr;
  logic [3:0]  dev_be;
  logic [31:0] dev_wdata;
  logic [2:0]  dev_ready;
  logic [31:0] dev_rdata0;
  logic [31:0] dev_rdata1;
  logic [31:0] dev_rdata2;

  // CPU and devices: drive requests, response acceptance and device returns
  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata, resp_ready,
           dev_ready, dev_rdata0, dev_rdata1, dev_rdata2,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           dev_sel, dev_we, dev_addr, dev_be, dev_wdata
  );

  // bridge: accepts requests, steers them to one device, returns the response
  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata, resp_ready,
           dev_ready, dev_rdata0, dev_rdata1, dev_rdata2,
    output req_ready, resp_valid, resp_rdata, resp_err,
           dev_sel, dev_we, dev_addr, dev_be, dev_wdata
  );
endinterface

// File: rtl/bridge_demux.sv
// Decodes one CPU load/store and steers it to DM, Timer0 or Timer1; returns read data or an error.
// Latency: accept at E, dev_sel in E+1, resp in E+2 with immediate ready; illegal access resp in E+1.
// One request outstanding: req_ready only in IDLE; response held until resp_ready.
module bridge_demux #(
  parameter logic [31:0] DM_HI    = 32'h0000_2FFF,
  parameter logic [31:0] TC0_BASE = 32'h0000_7F00,
  parameter logic [31:0] TC1_BASE = 32'h0000_7F10,
  parameter int          TIMEOUT  = 16
) (
  input logic          clk,
  input logic          reset,
  bridge_demux_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam int          CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [31:0] TC_SPAN = 32'd11;  // 12-byte timer windows, inclusive

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    sel_q;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic          in_dm;
  logic          in_tc0;
  logic          in_tc1;
  logic          legal;
  logic [2:0]    hit_sel;
  logic          sel_ready;
  logic [31:0]   sel_rdata;

  // Address decode of the incoming request; timers need word alignment and full-word stores
  always_comb begin
    in_dm   = (bus.req_addr <= DM_HI);
    in_tc0  = (bus.req_addr >= TC0_BASE) && (bus.req_addr <= TC0_BASE + TC_SPAN);
    in_tc1  = (bus.req_addr >= TC1_BASE) && (bus.req_addr <= TC1_BASE + TC_SPAN);
    legal   = 1'b0;
    hit_sel = 3'b000;
    if ($onehot({in_tc1, in_tc0, in_dm})) begin
      if (in_dm) begin
        legal = 1'b1;
      end else begin
        legal = (bus.req_addr[1:0] == 2'b00) && (!bus.req_we || bus.req_be == 4'b1111);
      end
    end
    if (legal) begin
      hit_sel = {in_tc1, in_tc0, in_dm};
    end
  end

  // Only the selected device's ready and read data are observed
  always_comb begin
    sel_ready = |(bus.dev_ready & sel_q);
    sel_rdata = 32'h0;
    unique case (sel_q)
      3'b001:  sel_rdata = bus.dev_rdata0;
      3'b010:  sel_rdata = bus.dev_rdata1;
      3'b100:  sel_rdata = bus.dev_rdata2;
      default: sel_rdata = 32'h0;
    endcase
  end

  // Request/access/response sequencing; reset aborts any access without a response
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      sel_q   <= 3'b000;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q  <= bus.req_addr;
            be_q    <= bus.req_be;
            wdata_q <= bus.req_wdata;
            rdata_q <= 32'h0;
            cnt     <= '0;
            if (legal) begin
              sel_q <= hit_sel;
              we_q  <= bus.req_we;
              err_q <= 1'b0;
              state <= ACCESS;
            end else begin
              sel_q <= 3'b000;
              we_q  <= 1'b0;
              err_q <= 1'b1;
              state <= RESP;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          // ready is checked first so it wins over a coinciding timeout
          if (sel_ready) begin
            rdata_q <= we_q ? 32'h0 : sel_rdata;
            err_q   <= 1'b0;
            sel_q   <= 3'b000;
            we_q    <= 1'b0;
            state   <= RESP;
          end else if (cnt == CNT_LAST) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b1;
            sel_q   <= 3'b000;
            we_q    <= 1'b0;
            state   <= RESP;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: begin
          sel_q <= 3'b000;
          we_q  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Output mapping: handshakes follow the state, device outputs come from the latches
  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.resp_valid = (state == RESP);
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
    bus.dev_sel    = sel_q;
    bus.dev_we     = we_q;
    bus.dev_addr   = addr_q;
    bus.dev_be     = be_q;
    bus.dev_wdata  = wdata_q;
  end

endmodule

// File: tb/tb_bridge_demux.sv
// Directed bench for bridge_demux: vector table plus hold and mid-access reset sequences.
module tb_bridge_demux;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  bridge_demux_if bus ();

  bridge_demux dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          rdy_at;   // access cycle in which ready is raised; 0 = never
    logic [2:0]  sel;      // expected device select; 0 = illegal
    int          cycles;   // expected cycles with dev_sel high
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   n;
    logic done;
    logic sel_bad;
    v = vecs[i];
    check($sformatf("v%0d_req_ready", i), 32'(bus.req_ready), 32'd1);
    bus.req_we    = v.we;
    bus.req_addr  = v.addr;
    bus.req_be    = v.be;
    bus.req_wdata = v.wdata;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    if (v.sel == 3'b000) begin
      check($sformatf("v%0d_err_resp_valid", i), 32'(bus.resp_valid), 32'd1);
      check($sformatf("v%0d_err_dev_sel", i), 32'(bus.dev_sel), 32'd0);
      check($sformatf("v%0d_err_dev_we", i), 32'(bus.dev_we), 32'd0);
      check($sformatf("v%0d_err_flag", i), 32'(bus.resp_err), 32'd1);
      check($sformatf("v%0d_err_rdata", i), bus.resp_rdata, 32'h0);
    end else begin
      check($sformatf("v%0d_dev_we", i), 32'(bus.dev_we), 32'(v.we));
      check($sformatf("v%0d_dev_addr", i), bus.dev_addr, v.addr);
      check($sformatf("v%0d_dev_be", i), 32'(bus.dev_be), 32'(v.be));
      check($sformatf("v%0d_dev_wdata", i), bus.dev_wdata, v.wdata);
      check($sformatf("v%0d_busy_req_ready", i), 32'(bus.req_ready), 32'd0);
      n       = 0;
      done    = 1'b0;
      sel_bad = 1'b0;
      for (int c = 1; c <= 40 && !done; c++) begin
        if (bus.dev_sel !== v.sel) sel_bad = 1'b1;
        // non-selected ready bits are always high to show they are ignored
        bus.dev_ready = (c == v.rdy_at) ? 3'b111 : ~v.sel;
        step();
        bus.dev_ready = 3'b000;
        n = c;
        if (bus.resp_valid === 1'b1) done = 1'b1;
      end
      check($sformatf("v%0d_resp_seen", i), 32'(done), 32'd1);
      check($sformatf("v%0d_sel_cycles", i), 32'(n), 32'(v.cycles));
      check($sformatf("v%0d_sel_stable", i), 32'(sel_bad), 32'd0);
      check($sformatf("v%0d_sel_dropped", i), 32'(bus.dev_sel), 32'd0);
      check($sformatf("v%0d_we_dropped", i), 32'(bus.dev_we), 32'd0);
      check($sformatf("v%0d_resp_err", i), 32'(bus.resp_err), 32'(v.err));
      check($sformatf("v%0d_resp_rdata", i), bus.resp_rdata, v.rdata);
    end
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    check($sformatf("v%0d_resp_done", i), 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    //            we    addr           be     wdata  rdy sel     cyc err   rdata
    vecs[0]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0, 1,  3'b001, 1,  1'b0, 32'hDEAD_BEEF};
    vecs[1]  = '{1'b1, 32'h0000_7F04, 4'hF, 32'h5, 3,  3'b010, 3,  1'b0, 32'h0};
    vecs[2]  = '{1'b0, 32'h0000_7F0C, 4'hF, 32'h0, 0,  3'b000, 0,  1'b1, 32'h0};
    vecs[3]  = '{1'b1, 32'h0000_7F10, 4'h3, 32'h9, 0,  3'b000, 0,  1'b1, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_7F10, 4'hF, 32'h0, 0,  3'b100, 16, 1'b1, 32'h0};
    vecs[5]  = '{1'b0, 32'h0000_2FFF, 4'h8, 32'h0, 2,  3'b001, 2,  1'b0, 32'hDEAD_BEEF};
    vecs[6]  = '{1'b0, 32'h0000_3000, 4'hF, 32'h0, 0,  3'b000, 0,  1'b1, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_7F12, 4'hF, 32'h0, 0,  3'b000, 0,  1'b1, 32'h0};
    vecs[8]  = '{1'b0, 32'h0000_7F18, 4'hF, 32'h0, 1,  3'b100, 1,  1'b0, 32'h2222_2222};
    vecs[9]  = '{1'b1, 32'h0000_0004, 4'h1, 32'hA5, 1, 3'b001, 1,  1'b0, 32'h0};
    vecs[10] = '{1'b0, 32'h0000_7F08, 4'hF, 32'h0, 16, 3'b010, 16, 1'b0, 32'h1111_1111};
    vecs[11] = '{1'b0, 32'h0000_7F1C, 4'hF, 32'h0, 0,  3'b000, 0,  1'b1, 32'h0};
    vecs[12] = '{1'b0, 32'h0000_7EFF, 4'hF, 32'h0, 0,  3'b000, 0,  1'b1, 32'h0};

    reset          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_be     = 4'h0;
    bus.req_wdata  = 32'h0;
    bus.resp_ready = 1'b0;
    bus.dev_ready  = 3'b000;
    bus.dev_rdata0 = 32'hDEAD_BEEF;
    bus.dev_rdata1 = 32'h1111_1111;
    bus.dev_rdata2 = 32'h2222_2222;
    step();
    step();
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'h0);
    check("rst_dev_sel", 32'(bus.dev_sel), 32'd0);
    check("rst_dev_we", 32'(bus.dev_we), 32'd0);
    check("rst_dev_addr", bus.dev_addr, 32'h0);
    reset = 1'b1;
    step();

    for (int i = 0; i < 13; i++) begin
      run_vec(i);
      step();
    end

    // Response held for 5 cycles while the next request waits
    bus.req_addr  = 32'h0000_0040;
    bus.req_be    = 4'hF;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid  = 1'b0;
    bus.dev_rdata0 = 32'hCAFE_F00D;
    bus.dev_ready  = 3'b001;
    step();
    bus.dev_ready  = 3'b000;
    bus.dev_rdata0 = 32'h1234_5678;
    bus.req_addr   = 32'h0000_0044;
    bus.req_valid  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("hold%0d_resp_valid", k), 32'(bus.resp_valid), 32'd1);
      check($sformatf("hold%0d_rdata", k), bus.resp_rdata, 32'hCAFE_F00D);
      check($sformatf("hold%0d_req_ready", k), 32'(bus.req_ready), 32'd0);
      check($sformatf("hold%0d_dev_sel", k), 32'(bus.dev_sel), 32'd0);
      step();
    end
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    check("hold_release_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("hold_release_req_ready", 32'(bus.req_ready), 32'd1);
    check("hold_release_dev_sel", 32'(bus.dev_sel), 32'd0);
    step();
    bus.req_valid = 1'b0;
    check("second_dev_sel", 32'(bus.dev_sel), 32'd1);
    check("second_dev_addr", bus.dev_addr, 32'h0000_0044);
    bus.dev_ready = 3'b001;
    step();
    bus.dev_ready = 3'b000;
    check("second_resp_valid", 32'(bus.resp_valid), 32'd1);
    check("second_rdata", bus.resp_rdata, 32'h1234_5678);
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    bus.dev_rdata0 = 32'hDEAD_BEEF;
    step();

    // Reset during the second cycle of a pending Timer0 access
    bus.req_addr  = 32'h0000_7F00;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    check("abort_dev_sel_before", 32'(bus.dev_sel), 32'd2);
    step();
    reset = 1'b0;
    step();
    check("abort_dev_sel", 32'(bus.dev_sel), 32'd0);
    check("abort_dev_we", 32'(bus.dev_we), 32'd0);
    check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("abort_req_ready", 32'(bus.req_ready), 32'd1);
    check("abort_dev_addr", bus.dev_addr, 32'h0);
    reset         = 1'b1;
    bus.dev_ready = 3'b111;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("abort_after%0d_resp_valid", k), 32'(bus.resp_valid), 32'd0);
      check($sformatf("abort_after%0d_dev_sel", k), 32'(bus.dev_sel), 32'd0);
    end
    bus.dev_ready = 3'b000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
